// File: rtl/picomem_pkg.sv
// Shared definitions for the PicoMem request queue: issue FSM encoding and request entry layout.
package picomem_pkg;

   localparam int unsigned PM_ADDR_W = 23;
   localparam int unsigned PM_STRB_W = 4;
   localparam int unsigned PM_DATA_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_GAP  = 2'd2
   } pm_state_e;

   typedef struct packed {
      logic [PM_ADDR_W-1:0] addr;
      logic [PM_STRB_W-1:0] wstrb;
      logic [PM_DATA_W-1:0] wdata;
   } pm_req_t;

   // Saturating 8-bit increment shared by the wait counter and the latency report.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? 8'hFF : v + 8'd1;
   endfunction

endpackage

// File: rtl/picomem_req_queue_sync_fifo.sv
// Synchronous FIFO with a registered occupancy count; pointers wrap naturally at DEPTH.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    i_rst,
   input  logic                    i_push,
   input  logic                    i_pop,
   input  logic [WIDTH-1:0]        i_wdata,
   output logic [WIDTH-1:0]        o_rdata,
   output logic                    o_full,
   output logic [$clog2(DEPTH):0]  o_count
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & (r_count != {CNT_W{1'b0}});
   assign o_rdata = r_mem[r_rd_ptr];
   assign o_count = r_count;

   // Storage array; contents need no reset because count gates every read.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   // Pointers and count; a coincident push and pop leaves the count unchanged.
   always_ff @(posedge clk) begin
      if (i_rst) begin
         r_wr_ptr <= {PTR_W{1'b0}};
         r_rd_ptr <= {PTR_W{1'b0}};
         r_count  <= {CNT_W{1'b0}};
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/picomem_req_queue.sv
// Request queue in front of PicoMem_PSRAM_V2: buffers word requests, issues them one at a
// time, and returns in-order completion pulses with measured latency and a timeout watchdog.
module picomem_req_queue
   import picomem_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 100,
   parameter int unsigned ADDR_W  = 23
) (
   input  logic              clk,
   input  logic              sys_reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [3:0]        req_wstrb,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_write,
   output logic              rsp_err,
   output logic [7:0]        rsp_latency,
   output logic              err_timeout,
   input  logic              mem_init_ready,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_wstrb,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);
   localparam int unsigned ENTRY_W = ADDR_W + PM_STRB_W + PM_DATA_W;
   localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
   localparam logic [7:0]  TO_LAST = 8'(TIMEOUT - 1);

   logic [ENTRY_W-1:0] w_push_entry;
   logic [ENTRY_W-1:0] w_head;
   logic               w_push;
   logic               w_pop;
   logic               w_full;
   logic [CNT_W-1:0]   w_count;
   logic               w_pending;
   logic               w_launch;
   logic               w_done;
   logic               w_abort;

   pm_state_e          r_state;
   pm_state_e          w_state_nxt;
   logic [7:0]         r_wait_cnt;
   logic               r_mem_valid;
   logic [ADDR_W-1:0]  r_mem_addr;
   logic [3:0]         r_mem_wstrb;
   logic [31:0]        r_mem_wdata;
   logic               r_rsp_valid;
   logic [31:0]        r_rsp_rdata;
   logic               r_rsp_write;
   logic               r_rsp_err;
   logic [7:0]         r_rsp_latency;
   logic               r_err_timeout;

   assign req_ready    = ~w_full;
   assign w_push       = req_valid & ~w_full;
   assign w_push_entry = {req_addr, req_wstrb, req_wdata};
   assign w_pending    = (w_count != {CNT_W{1'b0}});
   assign w_pop        = w_done | w_abort;

   sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .i_rst   (sys_reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_wdata (w_push_entry),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_count (w_count)
   );

   // Issue FSM state register.
   always_ff @(posedge clk) begin
      if (sys_reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state; GAP may launch directly so back-to-back issue keeps exactly one low cycle.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE, ST_GAP: begin
            if (w_pending && mem_init_ready) begin
               w_state_nxt = ST_BUSY;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (mem_ready || (r_wait_cnt == TO_LAST)) begin
               w_state_nxt = ST_GAP;
            end else begin
               w_state_nxt = ST_BUSY;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // FSM decode; ready on the timeout cycle counts as a normal completion.
   always_comb begin
      w_launch = 1'b0;
      w_done   = 1'b0;
      w_abort  = 1'b0;
      case (r_state)
         ST_IDLE, ST_GAP: begin
            w_launch = w_pending & mem_init_ready;
         end
         ST_BUSY: begin
            w_done  = mem_ready;
            w_abort = ~mem_ready & (r_wait_cnt == TO_LAST);
         end
         default: begin
            w_launch = 1'b0;
         end
      endcase
   end

   // Controller port, watchdog counter and response registers.
   always_ff @(posedge clk) begin
      if (sys_reset) begin
         r_mem_valid   <= 1'b0;
         r_mem_addr    <= {ADDR_W{1'b0}};
         r_mem_wstrb   <= 4'd0;
         r_mem_wdata   <= 32'd0;
         r_wait_cnt    <= 8'd0;
         r_rsp_valid   <= 1'b0;
         r_rsp_rdata   <= 32'd0;
         r_rsp_write   <= 1'b0;
         r_rsp_err     <= 1'b0;
         r_rsp_latency <= 8'd0;
         r_err_timeout <= 1'b0;
      end else begin
         r_rsp_valid <= 1'b0;
         if (w_launch) begin
            r_mem_valid <= 1'b1;
            r_mem_addr  <= w_head[ENTRY_W-1 -: ADDR_W];
            r_mem_wstrb <= w_head[PM_DATA_W +: PM_STRB_W];
            r_mem_wdata <= w_head[PM_DATA_W-1:0];
            r_wait_cnt  <= 8'd0;
         end else if (w_pop) begin
            r_mem_valid   <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_write   <= (r_mem_wstrb != 4'd0);
            r_rsp_err     <= w_abort;
            r_rsp_rdata   <= (w_done && (r_mem_wstrb == 4'd0)) ? mem_rdata : 32'd0;
            r_rsp_latency <= sat_inc8(r_wait_cnt);
            if (w_abort) begin
               r_err_timeout <= 1'b1;
            end
         end else if (r_state == ST_BUSY) begin
            r_wait_cnt <= sat_inc8(r_wait_cnt);
         end
      end
   end

   assign mem_valid   = r_mem_valid;
   assign mem_addr    = r_mem_addr;
   assign mem_wstrb   = r_mem_wstrb;
   assign mem_wdata   = r_mem_wdata;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_rdata   = r_rsp_rdata;
   assign rsp_write   = r_rsp_write;
   assign rsp_err     = r_rsp_err;
   assign rsp_latency = r_rsp_latency;
   assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_picomem_req_queue.sv
// Directed bench for picomem_req_queue with a small controller model (fixed ready latency).
module tb_picomem_req_queue;
   import picomem_pkg::*;

   localparam int unsigned DEPTH   = 4;
   localparam int unsigned TIMEOUT = 100;
   localparam int unsigned ADDR_W  = 23;

   logic              clk = 1'b0;
   logic              sys_reset;
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic [3:0]        req_wstrb;
   logic [31:0]       req_wdata;
   logic              rsp_valid;
   logic [31:0]       rsp_rdata;
   logic              rsp_write;
   logic              rsp_err;
   logic [7:0]        rsp_latency;
   logic              err_timeout;
   logic              mem_init_ready;
   logic              mem_valid;
   logic              mem_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic [3:0]        mem_wstrb;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   always #5 clk = ~clk;

   picomem_req_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .sys_reset(sys_reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_wstrb(req_wstrb), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_write(rsp_write),
      .rsp_err(rsp_err), .rsp_latency(rsp_latency), .err_timeout(err_timeout),
      .mem_init_ready(mem_init_ready), .mem_valid(mem_valid), .mem_ready(mem_ready),
      .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   typedef struct {
      logic [31:0] rdata;
      logic        write;
      logic        err;
      logic [7:0]  lat;
      int          cyc;
   } rsp_t;

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   int          lat_cfg = 0;
   int          v_cyc = 0;
   logic        prev_valid = 1'b0;
   logic [31:0] last_wdata = 32'd0;
   logic [31:0] mem_model [int];
   rsp_t        rsp_q[$];
   int          rise_q[$];

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
      end
   endtask

   // One clock: capture DUT outputs after the edge, then drive the controller model.
   task automatic step();
      rsp_t r;
      @(posedge clk);
      #1;
      cyc++;
      if (rsp_valid) begin
         r.rdata = rsp_rdata; r.write = rsp_write; r.err = rsp_err;
         r.lat = rsp_latency; r.cyc = cyc;
         rsp_q.push_back(r);
      end
      if (mem_valid && !prev_valid) rise_q.push_back(cyc);
      prev_valid = mem_valid;
      if (mem_valid) v_cyc++; else v_cyc = 0;
      mem_ready = mem_valid && (lat_cfg != 0) && (v_cyc == lat_cfg);
      mem_rdata = 32'hA5A5_A5A5;
      if (mem_ready) begin
         if (mem_wstrb == 4'd0) begin
            mem_rdata = mem_model.exists(int'(mem_addr)) ? mem_model[int'(mem_addr)] : 32'd0;
         end else begin
            last_wdata = mem_wdata;
            mem_model[int'(mem_addr)] = mem_wdata;
         end
      end
   endtask

   task automatic push(input logic [ADDR_W-1:0] a, input logic [3:0] s, input logic [31:0] d,
                       output int acc);
      req_addr = a; req_wstrb = s; req_wdata = d; req_valid = 1'b1;
      acc = -1;
      for (int i = 0; i < 400; i++) begin
         if (req_ready) begin
            acc = cyc;
            step();
            break;
         end
         step();
      end
      req_valid = 1'b0;
      chk("push_accepted", 64'(acc >= 0), 64'd1);
   endtask

   task automatic wait_rsp(input int n, input int bound);
      for (int i = 0; i < bound && rsp_q.size() < n; i++) step();
      chk("rsp_count", 64'(rsp_q.size()), 64'(n));
   endtask

   task automatic clear_q();
      rsp_q.delete();
      rise_q.delete();
   endtask

   initial begin
      int   acc;
      int   popped;
      rsp_t r;

      sys_reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_wstrb = 4'd0; req_wdata = 32'd0;
      mem_init_ready = 1'b0; mem_ready = 1'b0; mem_rdata = 32'd0;
      step(); step();
      chk("rst_mem_valid", 64'(mem_valid), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_err_to", 64'(err_timeout), 64'd0);
      chk("rst_latency", 64'(rsp_latency), 64'd0);
      chk("rst_rdata", 64'(rsp_rdata), 64'd0);
      chk("rst_count", 64'(dut.u_fifo.o_count), 64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'd1);
      sys_reset = 1'b0;
      step();

      // Single write, ready on the 9th valid cycle.
      clear_q(); lat_cfg = 9; mem_init_ready = 1'b1;
      push(23'h000004, 4'b1111, 32'h11773C3C, acc);
      wait_rsp(1, 60);
      chk("w1_rises", 64'(rise_q.size()), 64'd1);
      if (rise_q.size() > 0) chk("w1_rise_cyc", 64'(rise_q[0]), 64'(acc + 2));
      if (rsp_q.size() > 0 && rise_q.size() > 0) begin
         r = rsp_q[0];
         chk("w1_rsp_cyc", 64'(r.cyc), 64'(rise_q[0] + 9));
         chk("w1_write", 64'(r.write), 64'd1);
         chk("w1_err", 64'(r.err), 64'd0);
         chk("w1_lat", 64'(r.lat), 64'd9);
         chk("w1_rdata", 64'(r.rdata), 64'd0);
      end
      chk("w1_mem_wdata", 64'(last_wdata), 64'h11773C3C);
      for (int i = 0; i < 5; i++) step();
      chk("w1_single_pulse", 64'(rsp_q.size()), 64'd1);

      // Fill with init low, then full+pop refusal, then in-order drain.
      clear_q(); lat_cfg = 3; mem_init_ready = 1'b0;
      for (int k = 1; k <= 5; k++) mem_model[k * 16] = 32'h1000_0000 + 32'(k);
      for (int k = 1; k <= 4; k++) push(23'(k * 16), 4'd0, 32'd0, acc);
      chk("fill_req_ready", 64'(req_ready), 64'd0);
      req_addr = 23'h50; req_wstrb = 4'd0; req_wdata = 32'd0; req_valid = 1'b1;
      for (int i = 0; i < 3; i++) step();
      chk("fill_no_issue", 64'(rise_q.size()), 64'd0);
      chk("fill_5th_pending", 64'(req_ready), 64'd0);
      chk("fill_count", 64'(dut.u_fifo.o_count), 64'd4);
      mem_init_ready = 1'b1;
      popped = 0;
      for (int i = 0; i < 40 && popped == 0; i++) begin
         step();
         if (mem_ready) begin
            chk("full_pop_rdy", 64'(req_ready), 64'd0);
            step();
            req_valid = 1'b0;
            chk("full_pop_cnt", 64'(dut.u_fifo.o_count), 64'd3);
            popped = 1;
         end
      end
      chk("full_pop_seen", 64'(popped), 64'd1);
      push(23'h50, 4'd0, 32'd0, acc);
      wait_rsp(5, 200);
      chk("fill_rises", 64'(rise_q.size()), 64'd5);
      for (int k = 0; k < 5 && k < rsp_q.size(); k++) begin
         chk($sformatf("fill_rdata%0d", k), 64'(rsp_q[k].rdata), 64'(32'h1000_0000 + 32'(k + 1)));
         chk($sformatf("fill_lat%0d", k), 64'(rsp_q[k].lat), 64'd3);
      end
      for (int k = 0; k + 1 < rise_q.size(); k++)
         chk($sformatf("fill_gap%0d", k), 64'(rise_q[k + 1] - rise_q[k]), 64'd4);

      // Read data path.
      clear_q(); lat_cfg = 2;
      mem_model[32'h7FFFFC] = 32'hDEADBEEF;
      push(23'h7FFFFC, 4'd0, 32'd0, acc);
      wait_rsp(1, 40);
      if (rsp_q.size() > 0) begin
         chk("rd_rdata", 64'(rsp_q[0].rdata), 64'hDEADBEEF);
         chk("rd_write", 64'(rsp_q[0].write), 64'd0);
         chk("rd_lat", 64'(rsp_q[0].lat), 64'd2);
      end

      // Timeout: controller never answers.
      clear_q(); lat_cfg = 0;
      push(23'h000100, 4'b1111, 32'hCAFEF00D, acc);
      wait_rsp(1, 150);
      if (rsp_q.size() > 0 && rise_q.size() > 0) begin
         r = rsp_q[0];
         chk("to_rsp_cyc", 64'(r.cyc), 64'(rise_q[0] + 100));
         chk("to_err", 64'(r.err), 64'd1);
         chk("to_rdata", 64'(r.rdata), 64'd0);
         chk("to_write", 64'(r.write), 64'd1);
         chk("to_lat", 64'(r.lat), 64'd100);
      end
      chk("to_sticky", 64'(err_timeout), 64'd1);
      chk("to_valid_low", 64'(mem_valid), 64'd0);
      clear_q(); lat_cfg = 4;
      push(23'h10, 4'd0, 32'd0, acc);
      wait_rsp(1, 40);
      if (rsp_q.size() > 0) begin
         chk("after_to_err", 64'(rsp_q[0].err), 64'd0);
         chk("after_to_rdata", 64'(rsp_q[0].rdata), 64'h1000_0001);
         chk("after_to_lat", 64'(rsp_q[0].lat), 64'd4);
      end
      chk("after_to_sticky", 64'(err_timeout), 64'd1);

      // Ready on the last watchdog cycle wins.
      clear_q(); lat_cfg = 100;
      push(23'h20, 4'd0, 32'd0, acc);
      wait_rsp(1, 150);
      if (rsp_q.size() > 0) begin
         chk("race_err", 64'(rsp_q[0].err), 64'd0);
         chk("race_lat", 64'(rsp_q[0].lat), 64'd100);
         chk("race_rdata", 64'(rsp_q[0].rdata), 64'h1000_0002);
      end
      chk("race_sticky", 64'(err_timeout), 64'd1);

      // Reset while busy with three requests queued.
      clear_q(); lat_cfg = 0;
      for (int k = 0; k < 3; k++) push(23'(32'h200 + 32'(k * 4)), 4'b1111, 32'(k), acc);
      for (int i = 0; i < 10 && !mem_valid; i++) step();
      chk("rb_busy", 64'(mem_valid), 64'd1);
      sys_reset = 1'b1;
      step();
      chk("rb_valid_low", 64'(mem_valid), 64'd0);
      chk("rb_count", 64'(dut.u_fifo.o_count), 64'd0);
      chk("rb_err_clr", 64'(err_timeout), 64'd0);
      sys_reset = 1'b0;
      step();
      chk("rb_req_ready", 64'(req_ready), 64'd1);
      for (int i = 0; i < 10; i++) step();
      chk("rb_no_rsp", 64'(rsp_q.size()), 64'd0);
      chk("rb_no_reissue", 64'(rise_q.size()), 64'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
